// File: rtl/cic_comp_pkg.sv
// cic_comp_pkg: shared constants for the CIC droop-compensation FIR.
//   DW/CW/TAPS/ACCW   : sample, coefficient, tap-count and accumulator widths
//   RND_SHIFT         : output scaling (coefficient DC gain is 2^12)
//   ST_*              : FSM state encoding
//   coef_at()         : half coefficient table c0..c7 (c7 is the centre tap)
//   wrap15()          : modulo-15 reduction for delay-line addressing
package cic_comp_pkg;

  localparam int DW        = 16;
  localparam int CW        = 14;
  localparam int TAPS      = 15;
  localparam int ACCW      = 34;
  localparam int RND_SHIFT = 12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_RND  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  // Symmetric filter: c[14-k] = c[k], so only the first half is stored.
  function automatic logic signed [CW-1:0] coef_at(input logic [2:0] k);
    case (k)
      3'd0:    coef_at = -14'sd4;
      3'd1:    coef_at =  14'sd6;
      3'd2:    coef_at = -14'sd10;
      3'd3:    coef_at =  14'sd18;
      3'd4:    coef_at = -14'sd34;
      3'd5:    coef_at =  14'sd72;
      3'd6:    coef_at = -14'sd200;
      3'd7:    coef_at =  14'sd4400;
      default: coef_at =  14'sd0;
    endcase
  endfunction

  // Inputs never exceed 29, so one conditional subtract is enough.
  function automatic logic [3:0] wrap15(input logic [4:0] v);
    logic [4:0] t;
    t = v - 5'd15;
    if (v >= 5'd15) begin
      wrap15 = t[3:0];
    end else begin
      wrap15 = v[3:0];
    end
  endfunction

endpackage

// File: rtl/cic_comp_fir_if.sv
// cic_comp_fir_if: sample/status bundle between the CIC, the FIR and the sink.
//   cfir_din/cfir_din_vld   : input sample + 1-cycle strobe (master -> slave)
//   cfir_dout/cfir_dout_vld : filtered sample + 1-cycle update strobe (slave -> master)
//   cfir_busy               : FIR is computing (slave -> master)
//   cfir_ovr_err            : sticky overrun flag (slave -> master)
interface cic_comp_fir_if;
  import cic_comp_pkg::*;

  logic signed [DW-1:0] cfir_din;
  logic                 cfir_din_vld;
  logic signed [DW-1:0] cfir_dout;
  logic                 cfir_dout_vld;
  logic                 cfir_busy;
  logic                 cfir_ovr_err;

  modport master (
    output cfir_din, cfir_din_vld,
    input  cfir_dout, cfir_dout_vld, cfir_busy, cfir_ovr_err
  );

  modport slave (
    input  cfir_din, cfir_din_vld,
    output cfir_dout, cfir_dout_vld, cfir_busy, cfir_ovr_err
  );
endinterface

// File: rtl/cic_comp_mac.sv
// cic_comp_mac: single multiply-accumulate lane for the symmetric FIR.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : zero the accumulator (takes priority over i_en)
//   i_en         : add (i_xa + i_xb) * i_coef to the accumulator
//   i_xa, i_xb   : the two mirrored delay-line samples (i_xb = 0 for the centre tap)
//   i_coef       : coefficient for this step
//   o_acc        : accumulator value
module cic_comp_mac
  import cic_comp_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clr,
  input  logic                   i_en,
  input  logic signed [DW-1:0]   i_xa,
  input  logic signed [DW-1:0]   i_xb,
  input  logic signed [CW-1:0]   i_coef,
  output logic signed [ACCW-1:0] o_acc
);

  logic signed [DW:0]      w_pre;
  logic signed [DW+CW:0]   w_prod;
  logic signed [ACCW-1:0]  r_acc;

  // Pre-add in 17 bits so the mirrored pair can never overflow.
  assign w_pre  = {i_xa[DW-1], i_xa} + {i_xb[DW-1], i_xb};
  assign w_prod = w_pre * i_coef;

  // Accumulator: clear at the start of each output, add once per MAC step.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + {{(ACCW-DW-CW-1){w_prod[DW+CW]}}, w_prod};
    end else begin
      r_acc <= r_acc;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: 15-tap symmetric droop-compensation FIR behind the CIC decimator.
//   One shared MAC walks the 8 mirrored tap pairs, then rounds (half up), saturates
//   and registers the result; 10 clocks from accepted strobe to cfir_dout_vld.
//   cfir_clk  : clock, rising edge
//   cfir_rst  : synchronous active-high reset
//   cfir_bus  : cic_comp_fir_if.slave (din/din_vld in; dout/dout_vld/busy/ovr_err out)
// Build option: define CFIR_DECIM2_EN for an extra decimate-by-2 (every sample is
//   stored, only every second accepted sample produces an output).
module cic_comp_fir
  import cic_comp_pkg::*;
(
  input  logic           cfir_clk,
  input  logic           cfir_rst,
  cic_comp_fir_if.slave  cfir_bus
);

  logic [1:0]            r_state;
  logic [2:0]            r_k;
  logic [3:0]            r_wr_ptr;
  logic [3:0]            r_base;
  logic signed [DW-1:0]  r_mem [0:TAPS-1];
  logic signed [DW-1:0]  r_res;
  logic signed [DW-1:0]  r_dout;
  logic                  r_dout_vld;
  logic                  r_busy;
  logic                  r_ovr_err;

  logic                  w_accept;
  logic                  w_start;
  logic [3:0]            w_addr_a;
  logic [3:0]            w_addr_b;
  logic signed [DW-1:0]  w_xa;
  logic signed [DW-1:0]  w_xb;
  logic signed [CW-1:0]  w_coef;
  logic signed [ACCW-1:0] w_acc;
  logic signed [ACCW-1:0] w_rnd;
  logic signed [ACCW-1:0] w_shift;
  logic signed [DW-1:0]  w_sat;

  // Samples are only taken in IDLE; anything else is an overrun.
  assign w_accept = cfir_bus.cfir_din_vld && (r_state == ST_IDLE);

`ifdef CFIR_DECIM2_EN
  logic r_phase;

  assign w_start = w_accept && r_phase;

  // Decimation phase: flips on every stored sample, compute only on odd ones.
  always_ff @(posedge cfir_clk) begin
    if (cfir_rst) begin
      r_phase <= 1'b0;
    end else if (w_accept) begin
      r_phase <= ~r_phase;
    end else begin
      r_phase <= r_phase;
    end
  end
`else
  assign w_start = w_accept;
`endif

  // Mirrored read addresses: r_base holds the newest sample x[n];
  // x[n-k] is at base-k, x[n-14+k] is at base+1+k (both modulo 15).
  always_comb begin
    w_addr_a = wrap15({1'b0, r_base} + 5'd15 - {2'b00, r_k});
    w_addr_b = wrap15({1'b0, r_base} + 5'd1 + {2'b00, r_k});
    w_xa     = r_mem[w_addr_a];
    w_coef   = coef_at(r_k);
    // The centre tap has no partner; both addresses coincide there.
    if (r_k == 3'd7) begin
      w_xb = '0;
    end else begin
      w_xb = r_mem[w_addr_b];
    end
  end

  cic_comp_mac u_mac (
    .i_clk  (cfir_clk),
    .i_rst  (cfir_rst),
    .i_clr  (w_start),
    .i_en   (r_state == ST_MAC),
    .i_xa   (w_xa),
    .i_xb   (w_xb),
    .i_coef (w_coef),
    .o_acc  (w_acc)
  );

  // Round half up, scale by 2^-12, clamp to the 16-bit output range.
  always_comb begin
    w_rnd   = w_acc + 34'sd2048;
    w_shift = w_rnd >>> RND_SHIFT;
    if (w_shift > 34'sd32767) begin
      w_sat = 16'sh7fff;
    end else if (w_shift < -34'sd32768) begin
      w_sat = 16'sh8000;
    end else begin
      w_sat = w_shift[DW-1:0];
    end
  end

  // Control FSM, delay line, output register and status flags.
  always_ff @(posedge cfir_clk) begin
    if (cfir_rst) begin
      r_state    <= ST_IDLE;
      r_k        <= 3'd0;
      r_wr_ptr   <= 4'd0;
      r_base     <= 4'd0;
      r_res      <= '0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
      r_busy     <= 1'b0;
      r_ovr_err  <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_dout_vld <= 1'b0;
      if (cfir_bus.cfir_din_vld && (r_state != ST_IDLE)) begin
        r_ovr_err <= 1'b1;
      end else begin
        r_ovr_err <= r_ovr_err;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mem[r_wr_ptr] <= cfir_bus.cfir_din;
            r_base          <= r_wr_ptr;
            r_wr_ptr        <= (r_wr_ptr == 4'd14) ? 4'd0 : r_wr_ptr + 4'd1;
          end else begin
            r_wr_ptr        <= r_wr_ptr;
          end
          if (w_start) begin
            r_state <= ST_MAC;
            r_k     <= 3'd0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_MAC: begin
          r_k <= r_k + 3'd1;
          if (r_k == 3'd7) begin
            r_state <= ST_RND;
          end else begin
            r_state <= ST_MAC;
          end
        end
        ST_RND: begin
          r_res   <= w_sat;
          r_state <= ST_OUT;
        end
        ST_OUT: begin
          r_dout     <= r_res;
          r_dout_vld <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cfir_bus.cfir_dout     = r_dout;
  assign cfir_bus.cfir_dout_vld = r_dout_vld;
  assign cfir_bus.cfir_busy     = r_busy;
  assign cfir_bus.cfir_ovr_err  = r_ovr_err;

endmodule

// File: tb/tb_cic_comp_fir.sv
// tb_cic_comp_fir: self-checking bench for cic_comp_fir.
// A direct-form reference model (full 15-tap history) and fixed vector tables
// push expected outputs and arrival cycles into a scoreboard; a monitor pops
// and compares on every cfir_dout_vld.
module tb_cic_comp_fir;

  typedef struct {
    logic signed [15:0] din;
    logic signed [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  longint cyc = 0;

  int n_vec  = 0;
  int n_miss = 0;

  logic signed [15:0] exp_q [$];
  longint             tim_q [$];

  int  h_tab [15] = '{-4, 6, -10, 18, -34, 72, -200, 4400, -200, 72, -34, 18, -10, 6, -4};
  int  imp_exp [16] = '{-1, 1, -2, 4, -8, 18, -49, 1074, -49, 18, -8, 4, -2, 1, -1, 0};
  int  hist [15];
  bit  phase;
  vec_t tbl [16];

  cic_comp_fir_if u_bus ();

  cic_comp_fir dut (
    .cfir_clk (clk),
    .cfir_rst (rst),
    .cfir_bus (u_bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic signed [15:0] model_out();
    longint acc;
    acc = 0;
    for (int i = 0; i < 15; i++) acc += longint'(h_tab[i]) * longint'(hist[i]);
    acc = (acc + 2048) >>> 12;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc[15:0];
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle strobe; if it should be accepted, update the model
  // and queue the expected value (table value when use_tab is set).
  task automatic strobe(input logic signed [15:0] x, input bit accept,
                        input bit use_tab, input logic signed [15:0] texp);
    bit run;
    u_bus.cfir_din     = x;
    u_bus.cfir_din_vld = 1'b1;
    @(posedge clk);
    #1;
    u_bus.cfir_din_vld = 1'b0;
    if (accept) begin
      run = 1'b1;
`ifdef CFIR_DECIM2_EN
      run   = phase;
      phase = ~phase;
`endif
      for (int i = 14; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = int'(x);
      if (run) begin
        exp_q.push_back(use_tab ? texp : model_out());
        tim_q.push_back(cyc + 10);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    tim_q.delete();
    for (int i = 0; i < 15; i++) hist[i] = 0;
    phase = 1'b0;
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic signed [15:0] e;
    longint t;
    if (u_bus.cfir_dout_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_vld: got dout %0d at cycle %0d, expected no output", u_bus.cfir_dout, cyc);
      end else begin
        e = exp_q.pop_front();
        t = tim_q.pop_front();
        check("dout", u_bus.cfir_dout, e);
        check("latency", cyc, t);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl[i].din = (i == 0) ? 16'sd1000 : 16'sd0;
      tbl[i].exp = 16'(imp_exp[i]);
    end
    for (int i = 0; i < 15; i++) hist[i] = 0;
    phase = 1'b0;
    u_bus.cfir_din     = 16'sd0;
    u_bus.cfir_din_vld = 1'b0;

    // Reset, with a coincident strobe that must be ignored.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    u_bus.cfir_din     = 16'sd12345;
    u_bus.cfir_din_vld = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    u_bus.cfir_din_vld = 1'b0;
    check("rst_dout", u_bus.cfir_dout, 0);
    check("rst_dout_vld", u_bus.cfir_dout_vld, 0);
    check("rst_busy", u_bus.cfir_busy, 0);
    check("rst_ovr_err", u_bus.cfir_ovr_err, 0);
    wait_cycles(3);
    check("rst_strobe_ignored", u_bus.cfir_busy, 0);

    // Impulse response from the vector table.
    for (int i = 0; i < 16; i++) begin
      strobe(tbl[i].din, 1'b1, 1'b1, tbl[i].exp);
      wait_cycles(31);
    end

    // DC: settles to the input value from the 15th output on.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      strobe(16'sd1000, 1'b1, (i >= 14), 16'sd1000);
      wait_cycles(31);
    end

    // Saturation, positive then negative.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      strobe((h_tab[i] > 0) ? 16'sd32767 : -16'sd32768, 1'b1, (i == 14), 16'sd32767);
      wait_cycles(31);
    end
    for (int i = 0; i < 15; i++) begin
      strobe((h_tab[i] > 0) ? -16'sd32768 : 16'sd32767, 1'b1, (i == 14), -16'sd32768);
      wait_cycles(31);
    end

`ifndef CFIR_DECIM2_EN
    // Overrun 5 clocks into a run: dropped, sticky flag, run unaffected.
    do_reset();
    check("ovr_clear", u_bus.cfir_ovr_err, 0);
    strobe(16'sd10000, 1'b1, 1'b0, 16'sd0);
    check("busy_run", u_bus.cfir_busy, 1);
    wait_cycles(4);
    strobe(16'sd5000, 1'b0, 1'b0, 16'sd0);
    check("ovr_set", u_bus.cfir_ovr_err, 1);
    wait_cycles(20);
    check("ovr_sticky", u_bus.cfir_ovr_err, 1);
    check("busy_idle", u_bus.cfir_busy, 0);

    // Strobe coinciding with OUT->IDLE is dropped; the next cycle is accepted.
    strobe(16'sd20000, 1'b1, 1'b0, 16'sd0);
    wait_cycles(9);
    strobe(16'sd7000, 1'b0, 1'b0, 16'sd0);
    check("boundary_idle", u_bus.cfir_busy, 0);
    strobe(16'sd30000, 1'b1, 1'b0, 16'sd0);
    check("boundary_accept", u_bus.cfir_busy, 1);
    wait_cycles(20);

    // Reset in the middle of the MAC phase.
    strobe(16'sd1000, 1'b1, 1'b0, 16'sd0);
    wait_cycles(3);
    do_reset();
    check("midrst_dout", u_bus.cfir_dout, 0);
    check("midrst_vld", u_bus.cfir_dout_vld, 0);
    check("midrst_busy", u_bus.cfir_busy, 0);
    check("midrst_ovr", u_bus.cfir_ovr_err, 0);
    wait_cycles(14);
    strobe(16'sd1000, 1'b1, 1'b1, -16'sd1);
    wait_cycles(31);
    strobe(16'sd0, 1'b1, 1'b1, 16'sd1);
    wait_cycles(31);
`endif

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) wait_cycles(1);
    if (exp_q.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: got %0d outputs still pending, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
